// File: rtl/act_dispatch.sv
// Activation dispatcher: deals a packed activation stream in bursts, round-robin, across per-row FIFOs.
// Broadcast mode (extra cfg_bcast input) is compiled in when ACT_DISPATCH_BCAST_EN is defined.
module act_dispatch #(
  parameter int N_ROW      = 4,
  parameter int WID_ACT    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int WID_BURST  = 8,
  parameter int WID_TOTAL  = 16
) (
  input  logic                         clk_l,
  input  logic                         rst_n,
  input  logic                         cfg_start,
  input  logic [N_ROW-1:0]             cfg_row_mask,
  input  logic [WID_BURST-1:0]         cfg_burst_len,
  input  logic [WID_TOTAL-1:0]         cfg_total,
`ifdef ACT_DISPATCH_BCAST_EN
  input  logic                         cfg_bcast,
`endif
  input  logic [2*WID_ACT-1:0]         s_data,
  input  logic                         s_vld,
  output logic                         s_rdy,
  output logic [2*WID_ACT*N_ROW-1:0]   act_data_in,
  output logic [N_ROW-1:0]             act_data_in_vld,
  input  logic [N_ROW-1:0]             act_data_in_req,
  output logic                         busy,
  output logic                         done
);

  localparam int W  = 2 * WID_ACT;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = (N_ROW > 1) ? $clog2(N_ROW) : 1;
  localparam logic [CW-1:0]        DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [WID_BURST-1:0] BURST_ONE = {{(WID_BURST-1){1'b0}}, 1'b1};
  localparam logic [WID_TOTAL-1:0] TOTAL_ONE = {{(WID_TOTAL-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                 r_state;
  logic [N_ROW-1:0]       r_mask;
  logic [WID_BURST-1:0]   r_burst;
  logic [WID_TOTAL-1:0]   r_total;
  logic [WID_BURST-1:0]   r_word_cnt;
  logic [WID_TOTAL-1:0]   r_total_cnt;
  logic [RW-1:0]          r_row_ptr;
  logic                   r_done;

  logic [W-1:0]           r_mem [N_ROW][FIFO_DEPTH];
  logic [AW-1:0]          r_wp  [N_ROW];
  logic [AW-1:0]          r_rp  [N_ROW];
  logic [CW-1:0]          r_cnt [N_ROW];

  logic [N_ROW-1:0]       w_full;
  logic [N_ROW-1:0]       w_push;
  logic [N_ROW-1:0]       w_pop;
  logic                   w_all_empty;
  logic                   w_rdy_bcast;
  logic                   w_rdy_uni;
  logic                   w_acc;
  logic                   w_start;
  logic                   w_bcast;

  function automatic logic [RW-1:0] f_low_row(input logic [N_ROW-1:0] mask);
    logic [RW-1:0] res;
    logic          found;
    res   = {RW{1'b0}};
    found = 1'b0;
    for (int i = 0; i < N_ROW; i++) begin
      if (mask[i] && !found) begin
        res   = RW'(i);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Next set bit strictly above cur, wrapping to the lowest set bit.
  function automatic logic [RW-1:0] f_next_row(input logic [N_ROW-1:0] mask,
                                               input logic [RW-1:0]    cur);
    logic [RW-1:0] res;
    logic          found;
    res   = f_low_row(mask);
    found = 1'b0;
    for (int i = 0; i < N_ROW; i++) begin
      if (mask[i] && !found && (i > int'(cur))) begin
        res   = RW'(i);
        found = 1'b1;
      end
    end
    return res;
  endfunction

`ifdef ACT_DISPATCH_BCAST_EN
  logic r_bcast;

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      r_bcast <= 1'b0;
    end else if (w_start) begin
      r_bcast <= cfg_bcast;
    end else begin
      r_bcast <= r_bcast;
    end
  end

  assign w_bcast = r_bcast;
`else
  assign w_bcast = 1'b0;
`endif

  genvar g;
  generate
    for (g = 0; g < N_ROW; g++) begin : g_row_out
      assign act_data_in[g*W +: W] = r_mem[g][r_rp[g]];
      assign act_data_in_vld[g]    = (r_cnt[g] != {CW{1'b0}});
    end
  endgenerate

  assign w_start   = cfg_start && (r_state == ST_IDLE) &&
                     (cfg_row_mask != {N_ROW{1'b0}}) && (cfg_total != {WID_TOTAL{1'b0}});
  assign w_rdy_uni = ~w_full[r_row_ptr];
  assign s_rdy     = (r_state == ST_RUN) && (w_bcast ? w_rdy_bcast : w_rdy_uni);
  assign w_acc     = s_vld && s_rdy;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;

  // Per-row full/empty flags and push/pop strobes from the registered counts.
  always_comb begin
    w_all_empty = 1'b1;
    w_rdy_bcast = 1'b1;
    w_full      = {N_ROW{1'b0}};
    w_push      = {N_ROW{1'b0}};
    w_pop       = {N_ROW{1'b0}};
    for (int r = 0; r < N_ROW; r++) begin
      w_full[r]   = (r_cnt[r] == DEPTH_C);
      w_all_empty = w_all_empty & (r_cnt[r] == {CW{1'b0}});
      w_rdy_bcast = w_rdy_bcast & ~(w_full[r] & r_mask[r]);
      w_push[r]   = w_acc & (w_bcast ? r_mask[r] : (r_row_ptr == RW'(r)));
      w_pop[r]    = act_data_in_vld[r] & act_data_in_req[r];
    end
  end

  // FIFO storage; contents are don't-care while a row is empty, so no reset.
  always_ff @(posedge clk_l) begin
    for (int r = 0; r < N_ROW; r++) begin
      if (w_push[r]) begin
        r_mem[r][r_wp[r]] <= s_data;
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N_ROW; r++) begin
        r_wp[r]  <= {AW{1'b0}};
        r_rp[r]  <= {AW{1'b0}};
        r_cnt[r] <= {CW{1'b0}};
      end
    end else begin
      for (int r = 0; r < N_ROW; r++) begin
        if (w_push[r]) begin
          r_wp[r] <= r_wp[r] + 1'b1;
        end
        if (w_pop[r]) begin
          r_rp[r] <= r_rp[r] + 1'b1;
        end
        case ({w_push[r], w_pop[r]})
          2'b10:   r_cnt[r] <= r_cnt[r] + 1'b1;
          2'b01:   r_cnt[r] <= r_cnt[r] - 1'b1;
          default: r_cnt[r] <= r_cnt[r];
        endcase
      end
    end
  end

  // Job sequencing: config latch, burst/row stepping, drain and done pulse.
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mask      <= {N_ROW{1'b0}};
      r_burst     <= {WID_BURST{1'b0}};
      r_total     <= {WID_TOTAL{1'b0}};
      r_word_cnt  <= {WID_BURST{1'b0}};
      r_total_cnt <= {WID_TOTAL{1'b0}};
      r_row_ptr   <= {RW{1'b0}};
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_mask      <= cfg_row_mask;
            r_burst     <= (cfg_burst_len == {WID_BURST{1'b0}}) ? BURST_ONE : cfg_burst_len;
            r_total     <= cfg_total;
            r_word_cnt  <= {WID_BURST{1'b0}};
            r_total_cnt <= {WID_TOTAL{1'b0}};
            r_row_ptr   <= f_low_row(cfg_row_mask);
            r_state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_acc) begin
            r_total_cnt <= r_total_cnt + 1'b1;
            if (!w_bcast) begin
              if (r_word_cnt == r_burst - BURST_ONE) begin
                r_word_cnt <= {WID_BURST{1'b0}};
                r_row_ptr  <= f_next_row(r_mask, r_row_ptr);
              end else begin
                r_word_cnt <= r_word_cnt + 1'b1;
              end
            end
            if (r_total_cnt == r_total - TOTAL_ONE) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_all_empty) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_act_dispatch.sv
// Self-checking bench for act_dispatch: directed scenarios plus randomized jobs
// checked cycle by cycle against a queue-based model of the dispatch rules.
module tb_act_dispatch;

  localparam int NR    = 4;
  localparam int WA    = 16;
  localparam int W     = 2 * WA;
  localparam int DEPTH = 4;
  localparam int WB    = 8;
  localparam int WT    = 16;

  logic            clk_l = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_start = 1'b0;
  logic [NR-1:0]   cfg_row_mask = '0;
  logic [WB-1:0]   cfg_burst_len = '0;
  logic [WT-1:0]   cfg_total = '0;
`ifdef ACT_DISPATCH_BCAST_EN
  logic            cfg_bcast = 1'b0;
`endif
  logic [W-1:0]    s_data = '0;
  logic            s_vld = 1'b0;
  logic            s_rdy;
  logic [W*NR-1:0] act_data_in;
  logic [NR-1:0]   act_data_in_vld;
  logic [NR-1:0]   act_data_in_req = '0;
  logic            busy;
  logic            done;

  act_dispatch #(
    .N_ROW(NR), .WID_ACT(WA), .FIFO_DEPTH(DEPTH), .WID_BURST(WB), .WID_TOTAL(WT)
  ) dut (
    .clk_l(clk_l), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_row_mask(cfg_row_mask),
    .cfg_burst_len(cfg_burst_len), .cfg_total(cfg_total),
`ifdef ACT_DISPATCH_BCAST_EN
    .cfg_bcast(cfg_bcast),
`endif
    .s_data(s_data), .s_vld(s_vld), .s_rdy(s_rdy), .act_data_in(act_data_in),
    .act_data_in_vld(act_data_in_vld), .act_data_in_req(act_data_in_req),
    .busy(busy), .done(done)
  );

  always #5 clk_l = ~clk_l;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int          m_active = 0;
  int          m_done_pend = 0;
  int          m_acc = 0;
  int          m_total = 0;
  int          m_blen = 1;
  logic [3:0]  m_mask = '0;
  bit          m_bcast = 1'b0;
  logic [31:0] mq [NR][$];

  // observation logs
  logic [63:0] plog [NR];
  int          pcnt [NR];
  int          acc_obs = 0;
  int          done_cnt = 0;

  // stimulus knobs
  int          g_vld_pct = 100;
  int          g_req_pct = 100;
  bit          g_req_rand = 1'b0;
  logic [3:0]  g_req_fix = 4'hF;
  bit          g_seq = 1'b1;
  bit          g_junk = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Row that accepted word k lands on: the ((k / burst) mod nset)-th set bit of the mask.
  function automatic int tgt_row(input int k);
    int nset;
    int pos;
    int seen;
    nset = $countones(m_mask);
    pos  = (k / m_blen) % nset;
    seen = 0;
    for (int i = 0; i < NR; i++) begin
      if (m_mask[i]) begin
        if (seen == pos) return i;
        seen++;
      end
    end
    return 0;
  endfunction

  task automatic clear_logs();
    for (int r = 0; r < NR; r++) begin
      plog[r] = 64'd0;
      pcnt[r] = 0;
    end
    acc_obs  = 0;
    done_cnt = 0;
  endtask

  // One clock cycle: check outputs mid-cycle, advance the model across the edge.
  task automatic step();
    logic [3:0] ev;
    bit         er;
    bit         all_empty;
    int         act0;
    @(negedge clk_l);
    if (!rst_n) begin
      for (int r = 0; r < NR; r++) mq[r].delete();
      m_active    = 0;
      m_done_pend = 0;
      m_acc       = 0;
    end
    for (int r = 0; r < NR; r++) ev[r] = (mq[r].size() != 0);
    er = 1'b0;
    if (m_active != 0 && m_acc < m_total) begin
      if (m_bcast) begin
        er = 1'b1;
        for (int r = 0; r < NR; r++)
          if (m_mask[r] && mq[r].size() >= DEPTH) er = 1'b0;
      end else begin
        er = (mq[tgt_row(m_acc)].size() < DEPTH);
      end
    end
    check_val("s_rdy", s_rdy, er);
    check_val("busy", busy, (m_active != 0));
    check_val("done", done, (m_done_pend != 0));
    check_val("vld", act_data_in_vld, ev);
    for (int r = 0; r < NR; r++)
      if (ev[r]) check_val($sformatf("data%0d", r), act_data_in[r*W +: W], mq[r][0]);
    if (rst_n) begin
      for (int r = 0; r < NR; r++) begin
        if (act_data_in_vld[r] && act_data_in_req[r]) begin
          pcnt[r]++;
          plog[r] = (plog[r] << 4) | 64'(act_data_in[r*W +: 4] + 4'd1);
        end
      end
      if (s_vld && s_rdy) acc_obs++;
      if (done) done_cnt++;
      act0      = m_active;
      all_empty = 1'b1;
      for (int r = 0; r < NR; r++) all_empty &= (mq[r].size() == 0);
      m_done_pend = 0;
      if (m_active != 0 && m_acc == m_total && all_empty) begin
        m_active    = 0;
        m_done_pend = 1;
      end
      for (int r = 0; r < NR; r++)
        if (ev[r] && act_data_in_req[r]) void'(mq[r].pop_front());
      if (s_vld && er) begin
        if (m_bcast) begin
          for (int r = 0; r < NR; r++)
            if (m_mask[r]) mq[r].push_back(s_data);
        end else begin
          mq[tgt_row(m_acc)].push_back(s_data);
        end
        m_acc++;
      end
      if (act0 == 0 && cfg_start && cfg_row_mask != 4'd0 && cfg_total != 16'd0) begin
        m_mask   = cfg_row_mask;
        m_blen   = (cfg_burst_len == 8'd0) ? 1 : int'(cfg_burst_len);
        m_total  = int'(cfg_total);
`ifdef ACT_DISPATCH_BCAST_EN
        m_bcast  = cfg_bcast;
`else
        m_bcast  = 1'b0;
`endif
        m_acc    = 0;
        m_active = 1;
      end
    end
    @(posedge clk_l);
    #1;
  endtask

  task automatic drive();
    s_vld  = ($urandom_range(99) < g_vld_pct);
    s_data = g_seq ? 32'(m_acc) : $urandom();
    if (g_req_rand) begin
      for (int r = 0; r < NR; r++) act_data_in_req[r] = ($urandom_range(99) < g_req_pct);
    end else begin
      act_data_in_req = g_req_fix;
    end
    cfg_start     = g_junk && (m_active != 0) && ($urandom_range(9) == 0);
    cfg_row_mask  = 4'($urandom());
    cfg_burst_len = 8'($urandom_range(5));
    cfg_total     = 16'($urandom_range(30));
`ifdef ACT_DISPATCH_BCAST_EN
    cfg_bcast     = 1'($urandom());
`endif
  endtask

  task automatic start_job(input logic [3:0] mask, input int bl, input int tot, input bit bc);
    cfg_row_mask  = mask;
    cfg_burst_len = 8'(bl);
    cfg_total     = 16'(tot);
`ifdef ACT_DISPATCH_BCAST_EN
    cfg_bcast     = bc;
`else
    if (bc) $display("note: broadcast requested but not built in");
`endif
    s_vld     = 1'b0;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      step();
    end
  endtask

  task automatic run_job(input int budget);
    int n;
    n = 0;
    while ((m_active != 0 || m_done_pend != 0) && n < budget) begin
      drive();
      step();
      n++;
    end
    check_val("job_timeout", (m_active != 0 || m_done_pend != 0), 1'b0);
    s_vld     = 1'b0;
    cfg_start = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_logs();
    step();
    step();
    rst_n = 1'b1;
    step();

    // round-robin, burst 2
    clear_logs();
    g_seq = 1'b1; g_vld_pct = 100; g_req_rand = 1'b0; g_req_fix = 4'hF; g_junk = 1'b0;
    start_job(4'b1111, 2, 8, 1'b0);
    run_job(200);
    check_val("rr_row0", plog[0], 64'h12);
    check_val("rr_row1", plog[1], 64'h34);
    check_val("rr_row2", plog[2], 64'h56);
    check_val("rr_row3", plog[3], 64'h78);
    check_val("rr_done_cnt", done_cnt, 1);

    // sparse mask, partial final burst
    clear_logs();
    start_job(4'b1010, 3, 7, 1'b0);
    run_job(200);
    check_val("sp_row1", plog[1], 64'h1237);
    check_val("sp_row3", plog[3], 64'h456);
    check_val("sp_row0_cnt", pcnt[0], 0);
    check_val("sp_row2_cnt", pcnt[2], 0);

    // backpressure on a single row
    clear_logs();
    g_req_fix = 4'b0000;
    start_job(4'b0001, 1, 10, 1'b0);
    run_cycles(12);
    check_val("bp_accepted", acc_obs, DEPTH);
    check_val("bp_rdy_low", s_rdy, 1'b0);
    g_req_fix = 4'b0001;
    run_job(200);
    check_val("bp_pops", pcnt[0], 10);
    check_val("bp_order", plog[0], 64'h123456789A);

    // illegal starts, then a job with ignored starts while busy
    clear_logs();
    cfg_row_mask = 4'd0; cfg_total = 16'd5; cfg_start = 1'b1;
    step();
    cfg_row_mask = 4'hF; cfg_total = 16'd0;
    step();
    cfg_start = 1'b0;
    step();
    check_val("ill_busy", busy, 1'b0);
    g_req_rand = 1'b1; g_req_pct = 70; g_junk = 1'b1;
    start_job(4'b0101, 2, 9, 1'b0);
    run_job(400);
    check_val("ill_done_cnt", done_cnt, 1);
    g_junk = 1'b0;

    // reset in the middle of a job with data held
    g_req_rand = 1'b0; g_req_fix = 4'b0000;
    start_job(4'b1111, 1, 20, 1'b0);
    run_cycles(5);
    check_val("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    s_vld = 1'b0;
    step();
    check_val("rst_vld", act_data_in_vld, 4'd0);
    check_val("rst_rdy", s_rdy, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    step();
    rst_n = 1'b1;
    step();

`ifdef ACT_DISPATCH_BCAST_EN
    // broadcast with one stalled row
    clear_logs();
    g_req_fix = 4'b0011;
    start_job(4'b0111, 1, 3, 1'b1);
    run_cycles(6);
    check_val("bc_row0", pcnt[0], 3);
    check_val("bc_row1", pcnt[1], 3);
    check_val("bc_row2_vld", act_data_in_vld[2], 1'b1);
    check_val("bc_busy", busy, 1'b1);
    check_val("bc_no_done", done_cnt, 0);
    g_req_fix = 4'b0111;
    run_job(200);
    check_val("bc_row2", pcnt[2], 3);
    check_val("bc_done_cnt", done_cnt, 1);
`endif

    // randomized jobs
    g_seq = 1'b0; g_req_rand = 1'b1; g_junk = 1'b1;
    for (int j = 0; j < 40; j++) begin
      clear_logs();
      g_vld_pct = $urandom_range(30, 100);
      g_req_pct = $urandom_range(20, 100);
`ifdef ACT_DISPATCH_BCAST_EN
      start_job(4'($urandom_range(1, 15)), $urandom_range(0, 4), $urandom_range(1, 24),
                1'($urandom()));
`else
      start_job(4'($urandom_range(1, 15)), $urandom_range(0, 4), $urandom_range(1, 24), 1'b0);
`endif
      run_job(2000);
      check_val("rand_done_cnt", done_cnt, 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
